// File: rtl/dac_ser_pkg.sv
// Shared definitions for the DAC serializer: FSM encodings and frame sizing helper.
package dac_ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   function automatic int frame_bits(input int width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/dac_serializer_bclk_gen.sv
// Bit-clock generator: divides clk into a 50% duty bclk and flags the cycle in which bclk falls.
module bclk_gen #(
   parameter int BCLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_run,
   output logic o_bclk,
   output logic o_fall
);

   localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

   logic [DW-1:0] r_div_cnt;
   logic          r_bclk;
   logic          w_wrap;

   assign w_wrap = i_run && (r_div_cnt == DW'(BCLK_DIV - 1));
   assign o_fall = w_wrap && r_bclk;
   assign o_bclk = r_bclk;

   // Divider counter and bclk toggle; cleared and held low while not running
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div_cnt <= {DW{1'b0}};
         r_bclk    <= 1'b0;
      end else if (!i_run) begin
         r_div_cnt <= {DW{1'b0}};
         r_bclk    <= 1'b0;
      end else if (w_wrap) begin
         r_div_cnt <= {DW{1'b0}};
         r_bclk    <= ~r_bclk;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
         r_bclk    <= r_bclk;
      end
   end

endmodule

// File: rtl/dac_serializer.sv
// Left-justified stereo DAC serializer: captures DDS samples, sends each word MSB-first in both slots.
// Build option DAC_SER_OFFSET_BINARY_EN: send words as offset binary (MSB inverted).
module dac_serializer
   import dac_ser_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int BCLK_DIV = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_sample,
   input  logic             i_new_sample_ready,
   input  logic             i_ovr_clr,
   output logic             o_bclk,
   output logic             o_lrclk,
   output logic             o_sdata,
   output logic             o_frame_start,
   output logic             o_overrun
);

   localparam int FB = frame_bits(WIDTH);
   localparam int BW = $clog2(FB);

   state_t           r_state;
   logic [BW-1:0]    r_bit_cnt;
   logic [WIDTH-1:0] r_hold;
   logic [WIDTH-1:0] r_frame_word;
   logic [WIDTH-1:0] r_shreg;
   logic             r_pending;
   logic             r_lrclk;
   logic             r_frame_start;
   logic             r_overrun;

   logic             w_run;
   logic             w_fall;
   logic             w_wrap;
   logic             w_half;
   logic             w_load;
   logic [WIDTH-1:0] w_next_word;

   function automatic logic [WIDTH-1:0] to_frame(input logic [WIDTH-1:0] s);
`ifdef DAC_SER_OFFSET_BINARY_EN
      return {~s[WIDTH-1], s[WIDTH-2:0]};
`else
      return s;
`endif
   endfunction

   assign w_run  = (r_state != ST_IDLE);
   assign w_wrap = w_fall && (r_bit_cnt == BW'(FB - 1));
   assign w_half = w_fall && (r_bit_cnt == BW'(WIDTH - 1));
   // A frame boundary in DRAIN restarts seamlessly if en has come back
   assign w_load = ((r_state == ST_IDLE) && i_en) ||
                   (w_wrap && ((r_state == ST_RUN) || i_en));

   bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
      .i_clk   (i_clk),
      .i_rst_n (i_reset),
      .i_run   (w_run),
      .o_bclk  (o_bclk),
      .o_fall  (w_fall)
   );

   // Word selection for a load: fresh strobe beats held sample beats repeat of the last word
   always_comb begin
      w_next_word = r_frame_word;
      if (i_new_sample_ready) begin
         w_next_word = to_frame(i_sample);
      end else if (r_pending) begin
         w_next_word = to_frame(r_hold);
      end else begin
         w_next_word = r_frame_word;
      end
   end

   // Sample capture, pending flag and sticky overrun
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_hold    <= {WIDTH{1'b0}};
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (i_new_sample_ready) begin
            r_hold <= i_sample;
         end
         if (w_load) begin
            r_pending <= 1'b0;
         end else if (i_new_sample_ready) begin
            r_pending <= 1'b1;
         end
         if (i_new_sample_ready && r_pending && !w_load) begin
            r_overrun <= 1'b1;
         end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   // Link FSM, bit counter, slot select and shift register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state       <= ST_IDLE;
         r_bit_cnt     <= {BW{1'b0}};
         r_frame_word  <= {WIDTH{1'b0}};
         r_shreg       <= {WIDTH{1'b0}};
         r_lrclk       <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_load;
         case (r_state)
            ST_IDLE: begin
               r_bit_cnt <= {BW{1'b0}};
               r_lrclk   <= 1'b0;
               if (i_en) begin
                  r_state      <= ST_RUN;
                  r_frame_word <= w_next_word;
                  r_shreg      <= w_next_word;
               end else begin
                  r_shreg <= {WIDTH{1'b0}};
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (w_wrap && !w_load) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= i_en ? ST_RUN : ST_DRAIN;
               end
               if (w_wrap) begin
                  r_bit_cnt <= {BW{1'b0}};
                  r_lrclk   <= 1'b0;
                  if (w_load) begin
                     r_frame_word <= w_next_word;
                     r_shreg      <= w_next_word;
                  end else begin
                     r_shreg <= {WIDTH{1'b0}};
                  end
               end else if (w_half) begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  r_lrclk   <= 1'b1;
                  r_shreg   <= r_frame_word;
               end else if (w_fall) begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_lrclk       = r_lrclk;
   assign o_sdata       = r_shreg[WIDTH-1];
   assign o_frame_start = r_frame_start;
   assign o_overrun     = r_overrun;

endmodule
